// File: rtl/branch_sched.sv
// Branch scheduler: tracks in-flight predicted branches, resolves them in order,
// and raises a one-cycle flush plus a fetch-recover stall on a mispredict.
package branch_sched_pkg;
    localparam int unsigned word_width = 32;

    typedef struct packed {
        logic                  pred_taken;
        logic [word_width-1:0] pred_target;
        logic [word_width-1:0] fallthrough;
    } entry_t;
endpackage

module branch_sched
    import branch_sched_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned RECOVER_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        fetch_valid,
    input  logic                        is_branch,
    input  logic [word_width-1:0]       inst_addr,
    input  logic                        branch_predicted,
    input  logic [word_width-1:0]       branch_addr,
    output logic                        save_inst_addr,
    output logic                        fetch_stall,
    input  logic                        resolve_valid,
    input  logic                        resolve_taken,
    input  logic [word_width-1:0]       resolve_target,
    output logic                        handling_pred,
    output logic                        branch_taken,
    output logic                        flush,
    output logic [word_width-1:0]       redirect_addr,
    output logic [$clog2(DEPTH):0]      inflight_count,
    output logic                        resolve_err
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned RW = $clog2(RECOVER_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, TRACK, RECOVER} state_t;

    state_t          state, next_state;
    logic [RW-1:0]   rec_cnt, next_rec_cnt;
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count, count_adj, next_count;
    entry_t          mem [DEPTH];
    entry_t          head_entry;

    logic in_recover, full, enq, pop, mispredict;

    assign in_recover     = (state == RECOVER);
    assign full           = (count == CW'(DEPTH));
    assign save_inst_addr = fetch_valid & ~in_recover;
    assign fetch_stall    = full | in_recover;
    assign enq            = fetch_valid & is_branch & ~fetch_stall;
    assign pop            = resolve_valid & (count != '0);
    assign head_entry     = mem[head];
    assign mispredict     = pop & ((resolve_taken != head_entry.pred_taken) |
                                   (resolve_taken & (resolve_target != head_entry.pred_target)));
    assign count_adj      = count + CW'(enq) - CW'(pop);
    assign next_count     = mispredict ? '0 : count_adj;
    assign inflight_count = count;

    // FSM state and recover counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            rec_cnt <= '0;
        end else begin
            state   <= next_state;
            rec_cnt <= next_rec_cnt;
        end
    end

    // Occupancy picks IDLE/TRACK; a mispredict overrides with a timed recover window
    always_comb begin
        next_state   = state;
        next_rec_cnt = rec_cnt;
        if (mispredict) begin
            next_state   = RECOVER;
            next_rec_cnt = RW'(RECOVER_CYCLES - 1);
        end else if (in_recover) begin
            if (rec_cnt == '0) begin
                next_state = IDLE;
            end else begin
                next_rec_cnt = rec_cnt - RW'(1);
            end
        end else begin
            next_state = (next_count == '0) ? IDLE : TRACK;
        end
    end

    // Queue pointers; a mispredict empties the queue and drops a same-cycle enqueue
    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (mispredict) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) head <= head + PW'(1);
            if (enq) tail <= tail + PW'(1);
            count <= next_count;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail] <= '{pred_taken:  branch_predicted,
                           pred_target: branch_addr,
                           fallthrough: inst_addr + word_width'(4)};
        end
    end

    // Predictor-update and redirect strobes; taken/redirect hold between strobes
    always_ff @(posedge clk) begin
        if (!reset) begin
            handling_pred <= 1'b0;
            branch_taken  <= 1'b0;
            flush         <= 1'b0;
            redirect_addr <= '0;
            resolve_err   <= 1'b0;
        end else begin
            handling_pred <= pop;
            flush         <= mispredict;
            if (pop) branch_taken <= resolve_taken;
            if (mispredict) begin
                redirect_addr <= resolve_taken ? resolve_target : head_entry.fallthrough;
            end
            if (resolve_valid && count == '0) resolve_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_sched.sv
// Directed bench for branch_sched: queue-based reference model checked every
// cycle, plus hand-computed literal checks on the key scenarios.
module tb_branch_sched;
    import branch_sched_pkg::*;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned RC    = 2;
    localparam int unsigned W     = word_width;

    typedef struct {
        logic         taken;
        logic [W-1:0] target;
        logic [W-1:0] fall;
    } m_entry_t;

    logic clk, rst;
    logic fv, ib, bp, rv, rt;
    logic [W-1:0] ia, ba, rtg;
    logic save, stall, hp, bt, fl, err;
    logic [W-1:0] redir;
    logic [$clog2(DEPTH):0] cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 0;

    // reference model state
    m_entry_t     mq[$];
    int           rec_left = 0;
    logic         e_hp = 0, e_bt = 0, e_fl = 0, e_err = 0;
    logic [W-1:0] e_redir = '0;

    branch_sched #(.DEPTH(DEPTH), .RECOVER_CYCLES(RC)) dut (
        .clk(clk), .reset(rst),
        .fetch_valid(fv), .is_branch(ib), .inst_addr(ia),
        .branch_predicted(bp), .branch_addr(ba),
        .save_inst_addr(save), .fetch_stall(stall),
        .resolve_valid(rv), .resolve_taken(rt), .resolve_target(rtg),
        .handling_pred(hp), .branch_taken(bt), .flush(fl),
        .redirect_addr(redir), .inflight_count(cnt), .resolve_err(err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: evaluates the rules on each edge using the inputs in force before it
    initial forever begin
        @(posedge clk);
        if (!rst) begin
            mq.delete();
            rec_left = 0;
            e_hp = 0; e_bt = 0; e_fl = 0; e_err = 0; e_redir = '0;
        end else begin
            bit m_stall, m_enq, mis;
            m_entry_t h;
            m_stall = (mq.size() == DEPTH) || (rec_left > 0);
            m_enq   = fv && ib && !m_stall;
            if (rec_left > 0) rec_left--;
            e_hp = 0;
            e_fl = 0;
            mis  = 0;
            if (rv && mq.size() == 0) begin
                e_err = 1;
            end else if (rv) begin
                h    = mq.pop_front();
                e_hp = 1;
                e_bt = rt;
                mis  = (rt != h.taken) || (rt && rtg != h.target);
                if (mis) begin
                    e_fl     = 1;
                    e_redir  = rt ? rtg : h.fall;
                    mq.delete();
                    rec_left = RC;
                end
            end
            if (m_enq && !mis) mq.push_back('{taken: bp, target: ba, fall: ia + 32'd4});
        end
    end

    // Every-cycle compare against the model
    always @(negedge clk) begin
        if (started) begin
            check("handling_pred", 64'(hp), 64'(e_hp));
            check("branch_taken", 64'(bt), 64'(e_bt));
            check("flush", 64'(fl), 64'(e_fl));
            check("redirect_addr", 64'(redir), 64'(e_redir));
            check("inflight_count", 64'(cnt), 64'(mq.size()));
            check("resolve_err", 64'(err), 64'(e_err));
            check("fetch_stall", 64'(stall), 64'((mq.size() == DEPTH) || (rec_left > 0)));
            check("save_inst_addr", 64'(save), 64'(fv && rec_left == 0));
        end
    end

    task automatic idle();
        fv = 0; ib = 0; ia = '0; bp = 0; ba = '0; rv = 0; rt = 0; rtg = '0;
    endtask

    // Apply one cycle of inputs; returns #1 after the consuming edge with inputs idle
    task automatic tick(input logic f, input logic [W-1:0] a, input logic p, input logic [W-1:0] pa,
                        input logic r, input logic t, input logic [W-1:0] tg);
        fv = f; ib = f; ia = a; bp = p; ba = pa; rv = r; rt = t; rtg = tg;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) tick(0, '0, 0, '0, 0, 0, '0);
    endtask

    initial begin
        idle();
        rst = 0;
        nop(1);
        started = 1;
        nop(2);
        check("rst_count", 64'(cnt), 64'd0);
        check("rst_redirect", 64'(redir), 64'd0);
        check("rst_flags", 64'({hp, bt, fl, err}), 64'd0);
        rst = 1;
        nop(1);

        // correct not-taken prediction
        tick(1, 32'h100, 0, '0, 0, 0, '0);
        check("t28_count1", 64'(cnt), 64'd1);
        tick(0, '0, 0, '0, 1, 0, '0);
        check("t28_hp", 64'(hp), 64'd1);
        check("t28_bt", 64'(bt), 64'd0);
        check("t28_flush", 64'(fl), 64'd0);
        check("t28_count0", 64'(cnt), 64'd0);
        nop(1);
        check("t28_hp_pulse", 64'(hp), 64'd0);

        // predicted taken, actually not taken -> fallthrough redirect and stall
        tick(1, 32'h200, 1, 32'h180, 0, 0, '0);
        tick(0, '0, 0, '0, 1, 0, '0);
        check("t29_flush", 64'(fl), 64'd1);
        check("t29_redirect", 64'(redir), 64'h204);
        check("t29_stall1", 64'(stall), 64'd1);
        check("t29_count", 64'(cnt), 64'd0);
        nop(1);
        check("t29_flush_pulse", 64'(fl), 64'd0);
        check("t29_stall2", 64'(stall), 64'd1);
        nop(1);
        check("t29_stall_end", 64'(stall), 64'd0);

        // taken to the wrong target
        tick(1, 32'h2f0, 1, 32'h300, 0, 0, '0);
        tick(0, '0, 0, '0, 1, 1, 32'h340);
        check("t30_flush", 64'(fl), 64'd1);
        check("t30_redirect", 64'(redir), 64'h340);
        check("t30_bt", 64'(bt), 64'd1);
        nop(2);

        // fill the queue, then a blocked 5th branch with a correct resolve
        for (int i = 0; i < 4; i++) tick(1, 32'h400 + 32'(4 * i), 0, '0, 0, 0, '0);
        check("t31_count4", 64'(cnt), 64'd4);
        fv = 1; ib = 1; ia = 32'h410;
        #1;
        check("t31_stall_full", 64'(stall), 64'd1);
        check("t31_save", 64'(save), 64'd1);
        tick(1, 32'h410, 0, '0, 1, 0, '0);
        check("t31_count3", 64'(cnt), 64'd3);
        check("t31_redirect_hold", 64'(redir), 64'h340);
        tick(1, 32'h420, 0, '0, 1, 0, '0);
        check("t19_count_same", 64'(cnt), 64'd3);
        for (int i = 0; i < 3; i++) tick(0, '0, 0, '0, 1, 0, '0);
        check("t31_drained", 64'(cnt), 64'd0);
        check("t31_no_flush", 64'(fl), 64'd0);

        // enqueue dropped by a same-cycle mispredict
        tick(1, 32'h500, 0, '0, 0, 0, '0);
        tick(1, 32'h504, 1, 32'h600, 0, 0, '0);
        tick(1, 32'h508, 1, 32'h700, 1, 1, 32'h800);
        check("t32_count0", 64'(cnt), 64'd0);
        check("t32_redirect", 64'(redir), 64'h800);
        nop(2);

        // resolve on an empty queue is ignored but sticky-flags an error
        tick(0, '0, 0, '0, 1, 1, 32'h900);
        check("t33_err", 64'(err), 64'd1);
        check("t33_no_hp", 64'(hp), 64'd0);
        nop(2);
        check("t33_err_sticky", 64'(err), 64'd1);

        // reset in the middle of a recover window
        tick(1, 32'ha00, 0, '0, 0, 0, '0);
        tick(0, '0, 0, '0, 1, 1, 32'hb00);
        check("t33_rec_stall", 64'(stall), 64'd1);
        rst = 0;
        nop(1);
        check("t33_rst_flags", 64'({hp, bt, fl, err}), 64'd0);
        check("t33_rst_redirect", 64'(redir), 64'd0);
        check("t33_rst_stall", 64'(stall), 64'd0);
        rst = 1;
        nop(1);
        check("t33_post_flush", 64'(fl), 64'd0);
        check("t33_post_hp", 64'(hp), 64'd0);
        nop(2);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
